matmul_seq: RTL and testbench

MATMUL_SEQ -- requirements
Module: matmul_seq

---
 rtl/matmul_pkg.sv | 35 +++
 rtl/level_det.sv | 24 ++
 rtl/matmul_seq.sv | 191 +++++++++++++++++++
 tb/tb_matmul_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared state encoding, default sizes and address helper
// constants for the sequential matrix multiplier (R = A x B).
package matmul_pkg;

    // Default geometry of the multiplier.
    localparam int unsigned DEF_ROW   = 2;
    localparam int unsigned DEF_INNER = 2;
    localparam int unsigned DEF_COL   = 2;
    localparam int unsigned DEF_DW    = 8;
    localparam int unsigned DEF_AW    = 32;

    // Matrix sizes, in elements, for the default geometry.
    localparam int unsigned DEF_N_R = DEF_ROW * DEF_COL;
    localparam int unsigned DEF_N_A = DEF_ROW * DEF_INNER;
    localparam int unsigned DEF_N_B = DEF_INNER * DEF_COL;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_READ   = 3'd2,
        ST_MAC    = 3'd3,
        ST_WRITE  = 3'd4,
        ST_FINISH = 3'd5
    } mm_state_e;

    // Accumulator width: a full product plus one bit per doubling of
    // the number of terms summed, so the sum can never overflow.
    function automatic int unsigned acc_width(
        input int unsigned dw,
        input int unsigned inner
    );
        return 2 * dw + $clog2(inner);
    endfunction

endpackage

// File: rtl/level_det.sv
// level_det: rising-edge detector for a level request.
// Ports: slow_clk/rst (async, active-high), level_i, edge_o (comb pulse).
module level_det
    import matmul_pkg::*;
(
    input  logic slow_clk,
    input  logic rst,
    input  logic level_i,
    output logic edge_o
);

    logic level_q;

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign edge_o = level_i & ~level_q;

endmodule

// File: rtl/matmul_seq.sv
// matmul_seq: sequential unsigned matrix multiplier R = A x B, one MAC
// per two cycles, reading A/B and writing R through simple strobed ports.
// Ports: slow_clk, rst (async, active-high), start (level, edge-triggered),
//   rd_a/addr_a/data_a, rd_b/addr_b/data_b (read, data one cycle later),
//   wr_r/addr_r/val_r (write), busy, done and tx_start (completion pulses).
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int unsigned ROW   = DEF_ROW,
    parameter int unsigned INNER = DEF_INNER,
    parameter int unsigned COL   = DEF_COL,
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned SAT   = 0
) (
    input  logic          slow_clk,
    input  logic          rst,
    input  logic          start,
    output logic          rd_a,
    output logic [AW-1:0] addr_a,
    input  logic [DW-1:0] data_a,
    output logic          rd_b,
    output logic [AW-1:0] addr_b,
    input  logic [DW-1:0] data_b,
    output logic          wr_r,
    output logic [AW-1:0] addr_r,
    output logic [DW-1:0] val_r,
    output logic          busy,
    output logic          done,
    output logic          tx_start
);

    localparam int unsigned ACCW = acc_width(DW, INNER);

    localparam logic [AW-1:0]   ROW_LAST   = AW'(ROW - 1);
    localparam logic [AW-1:0]   INNER_LAST = AW'(INNER - 1);
    localparam logic [AW-1:0]   COL_LAST   = AW'(COL - 1);
    localparam logic [AW-1:0]   INNER_A    = AW'(INNER);
    localparam logic [AW-1:0]   COL_A      = AW'(COL);
    localparam logic [ACCW-1:0] MAXV       = ACCW'({DW{1'b1}});

    mm_state_e state_q, state_d;

    logic [AW-1:0]   i_q, i_d;
    logic [AW-1:0]   j_q, j_d;
    logic [AW-1:0]   k_q, k_d;
    logic [ACCW-1:0] acc_q, acc_d;

    logic            start_edge;
    logic            i_last, j_last, k_last;
    logic [AW-1:0]   a_idx, b_idx, r_idx;
    logic [ACCW-1:0] prod;
    logic [DW-1:0]   res;

    level_det u_det (
        .slow_clk (slow_clk),
        .rst      (rst),
        .level_i  (start),
        .edge_o   (start_edge)
    );

    assign i_last = (i_q == ROW_LAST);
    assign j_last = (j_q == COL_LAST);
    assign k_last = (k_q == INNER_LAST);

    // Row-major element addresses.
    assign a_idx = i_q * INNER_A + k_q;
    assign b_idx = k_q * COL_A + j_q;
    assign r_idx = i_q * COL_A + j_q;

    assign prod = ACCW'(data_a) * ACCW'(data_b);

    always_comb begin
        res = acc_q[DW-1:0];
        if ((SAT != 0) && (acc_q > MAXV)) begin
            res = MAXV[DW-1:0];
        end
    end

    // State register.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start edges outside IDLE are simply dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR:  state_d = ST_READ;
            ST_READ:   state_d = ST_MAC;
            ST_MAC:    state_d = k_last ? ST_WRITE : ST_READ;
            ST_WRITE:  state_d = (i_last && j_last) ? ST_FINISH : ST_CLEAR;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic: strobes and addresses are decoded from state only,
    // so an async reset of the state clears them immediately.
    always_comb begin
        busy     = 1'b1;
        done     = 1'b0;
        tx_start = 1'b0;
        rd_a     = 1'b0;
        rd_b     = 1'b0;
        wr_r     = 1'b0;
        addr_a   = '0;
        addr_b   = '0;
        addr_r   = '0;
        val_r    = '0;
        unique case (state_q)
            ST_IDLE: busy = 1'b0;
            ST_READ: begin
                rd_a   = 1'b1;
                rd_b   = 1'b1;
                addr_a = a_idx;
                addr_b = b_idx;
            end
            ST_WRITE: begin
                wr_r   = 1'b1;
                addr_r = r_idx;
                val_r  = res;
            end
            ST_FINISH: begin
                done     = 1'b1;
                tx_start = 1'b1;
            end
            default: ;
        endcase
    end

    // Counter and accumulator next-state.
    always_comb begin
        i_d   = i_q;
        j_d   = j_q;
        k_d   = k_q;
        acc_d = acc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    i_d = '0;
                    j_d = '0;
                    k_d = '0;
                end
            end
            ST_CLEAR: begin
                acc_d = '0;
                k_d   = '0;
            end
            ST_MAC: begin
                acc_d = acc_q + prod;
                if (!k_last) begin
                    k_d = k_q + AW'(1);
                end
            end
            ST_WRITE: begin
                if (j_last) begin
                    j_d = '0;
                    i_d = i_q + AW'(1);
                end else begin
                    j_d = j_q + AW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
        end else begin
            i_q   <= i_d;
            j_q   <= j_d;
            k_q   <= k_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: scoreboard bench for matmul_seq. Three instances: default
// 2x2x2 (SAT=0), the same with SAT=1, and a 2x3x1 geometry.
module tb_matmul_seq;

    typedef struct {
        int a;
        int v;
    } wr_t;

    logic slow_clk = 1'b0;
    always #5 slow_clk = ~slow_clk;

    logic rst = 1'b0;
    logic st_m = 1'b0;
    logic st_s = 1'b0;
    logic st_o = 1'b0;

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];

    logic        rda_m, rdb_m, wr_m, busy_m, done_m, tx_m;
    logic [31:0] aa_m, ab_m, ar_m;
    logic [7:0]  da_m, db_m, vr_m;

    logic        rda_s, rdb_s, wr_s, busy_s, done_s, tx_s;
    logic [31:0] aa_s, ab_s, ar_s;
    logic [7:0]  da_s, db_s, vr_s;

    logic        rda_o, rdb_o, wr_o, busy_o, done_o, tx_o;
    logic [31:0] aa_o, ab_o, ar_o;
    logic [7:0]  da_o, db_o, vr_o;

    matmul_seq u_dut (
        .slow_clk (slow_clk), .rst (rst), .start (st_m),
        .rd_a (rda_m), .addr_a (aa_m), .data_a (da_m),
        .rd_b (rdb_m), .addr_b (ab_m), .data_b (db_m),
        .wr_r (wr_m), .addr_r (ar_m), .val_r (vr_m),
        .busy (busy_m), .done (done_m), .tx_start (tx_m)
    );

    matmul_seq #(.SAT(1)) u_sat (
        .slow_clk (slow_clk), .rst (rst), .start (st_s),
        .rd_a (rda_s), .addr_a (aa_s), .data_a (da_s),
        .rd_b (rdb_s), .addr_b (ab_s), .data_b (db_s),
        .wr_r (wr_s), .addr_r (ar_s), .val_r (vr_s),
        .busy (busy_s), .done (done_s), .tx_start (tx_s)
    );

    matmul_seq #(.ROW(2), .INNER(3), .COL(1)) u_odd (
        .slow_clk (slow_clk), .rst (rst), .start (st_o),
        .rd_a (rda_o), .addr_a (aa_o), .data_a (da_o),
        .rd_b (rdb_o), .addr_b (ab_o), .data_b (db_o),
        .wr_r (wr_o), .addr_r (ar_o), .val_r (vr_o),
        .busy (busy_o), .done (done_o), .tx_start (tx_o)
    );

    // Synchronous-read memories: data valid the cycle after the strobe.
    always @(posedge slow_clk) begin
        if (rda_m) da_m <= mem_a[aa_m[3:0]];
        if (rdb_m) db_m <= mem_b[ab_m[3:0]];
        if (rda_s) da_s <= mem_a[aa_s[3:0]];
        if (rdb_s) db_s <= mem_b[ab_s[3:0]];
        if (rda_o) da_o <= mem_a[aa_o[3:0]];
        if (rdb_o) db_o <= mem_b[ab_o[3:0]];
    end

    int n_cmp = 0;
    int n_bad = 0;

    wr_t q_m[$];
    wr_t q_s[$];
    wr_t q_o[$];
    int  q_ob[$];

    int bc_m = 0, dc_m = 0, wc_m = 0, ra_m = 0, rb_m = 0;
    int bc_s = 0, dc_s = 0, wc_s = 0;
    int bc_o = 0, dc_o = 0, wc_o = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic clr();
        bc_m = 0; dc_m = 0; wc_m = 0; ra_m = 0; rb_m = 0;
        bc_s = 0; dc_s = 0; wc_s = 0;
        bc_o = 0; dc_o = 0; wc_o = 0;
    endtask

    // Monitor: default instance.
    always @(negedge slow_clk) begin
        wr_t e;
        logic bad;
        if (busy_m) begin
            bc_m++;
            bad = (rda_m && wr_m) || (rda_m != rdb_m)
                || (!rda_m && aa_m != 0) || (!rdb_m && ab_m != 0)
                || (!wr_m && (ar_m != 0 || vr_m != 0));
            chk("strobe_rules", bad, 0);
        end
        if (rda_m) ra_m++;
        if (rdb_m) rb_m++;
        if (wr_m) begin
            wc_m++;
            if (q_m.size() == 0) begin
                chk("m_wr_unexpected", ar_m, -1);
            end else begin
                e = q_m.pop_front();
                chk("m_wr_addr", ar_m, e.a);
                chk("m_wr_val", vr_m, e.v);
            end
        end
        if (done_m) begin
            dc_m++;
            chk("m_done_cycle", bc_m, 25);
            chk("m_tx_with_done", tx_m, 1);
        end else if (tx_m) begin
            chk("m_tx_alone", tx_m, 0);
        end
    end

    // Monitor: saturating instance.
    always @(negedge slow_clk) begin
        wr_t e;
        if (busy_s) bc_s++;
        if (wr_s) begin
            wc_s++;
            if (q_s.size() == 0) begin
                chk("s_wr_unexpected", ar_s, -1);
            end else begin
                e = q_s.pop_front();
                chk("s_wr_addr", ar_s, e.a);
                chk("s_wr_val", vr_s, e.v);
            end
        end
        if (done_s) begin
            dc_s++;
            chk("s_done_cycle", bc_s, 25);
        end
    end

    // Monitor: 2x3x1 instance, including the addr_b read sequence.
    always @(negedge slow_clk) begin
        wr_t e;
        int eb;
        if (busy_o) bc_o++;
        if (rdb_o) begin
            if (q_ob.size() == 0) begin
                chk("o_rdb_unexpected", ab_o, -1);
            end else begin
                eb = q_ob.pop_front();
                chk("o_addr_b", ab_o, eb);
            end
        end
        if (wr_o) begin
            wc_o++;
            if (q_o.size() == 0) begin
                chk("o_wr_unexpected", ar_o, -1);
            end else begin
                e = q_o.pop_front();
                chk("o_wr_addr", ar_o, e.a);
                chk("o_wr_val", vr_o, e.v);
            end
        end
        if (done_o) begin
            dc_o++;
            chk("o_done_cycle", bc_o, 17);
        end
    end

    task automatic push_m(input int a, input int v);
        wr_t e;
        e.a = a;
        e.v = v;
        q_m.push_back(e);
    endtask

    task automatic load2(input int a0, input int a1, input int a2, input int a3,
                         input int b0, input int b1, input int b2, input int b3);
        mem_a[0] = 8'(a0); mem_a[1] = 8'(a1);
        mem_a[2] = 8'(a2); mem_a[3] = 8'(a3);
        mem_b[0] = 8'(b0); mem_b[1] = 8'(b1);
        mem_b[2] = 8'(b2); mem_b[3] = 8'(b3);
    endtask

    task automatic pulse(input int sel);
        @(posedge slow_clk);
        #1;
        if (sel == 0) st_m = 1'b1;
        else if (sel == 1) st_s = 1'b1;
        else st_o = 1'b1;
        repeat (2) @(posedge slow_clk);
        #1;
        st_m = 1'b0;
        st_s = 1'b0;
        st_o = 1'b0;
    endtask

    task automatic wait_idle(input int sel);
        bit seen;
        logic b;
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge slow_clk);
            #1;
            b = (sel == 0) ? busy_m : (sel == 1) ? busy_s : busy_o;
            if (b) seen = 1'b1;
            else if (seen) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_idle: instance %0d never completed, want idle", sel);
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_busy"}, busy_m, 0);
        chk({nm, "_done"}, done_m, 0);
        chk({nm, "_tx"}, tx_m, 0);
        chk({nm, "_rd"}, {rda_m, rdb_m, wr_m}, 0);
        chk({nm, "_addr"}, aa_m | ab_m | ar_m, 0);
        chk({nm, "_val"}, vr_m, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        #2 rst = 1'b1;
        #1 chk_quiet("reset_held");
        repeat (3) @(posedge slow_clk);
        #1 rst = 1'b0;
        @(posedge slow_clk);
        #1 chk_quiet("after_reset");

        // Basic 2x2 product.
        clr();
        load2(1, 2, 3, 4, 5, 6, 7, 8);
        push_m(0, 19); push_m(1, 22); push_m(2, 43); push_m(3, 50);
        pulse(0);
        wait_idle(0);
        chk("basic_writes", wc_m, 4);
        chk("basic_dones", dc_m, 1);
        chk("basic_busy_len", bc_m, 25);
        chk("basic_q_left", q_m.size(), 0);

        // Identity A.
        clr();
        load2(1, 0, 0, 1, 9, 8, 7, 6);
        push_m(0, 9); push_m(1, 8); push_m(2, 7); push_m(3, 6);
        pulse(0);
        wait_idle(0);
        chk("ident_writes", wc_m, 4);
        chk("ident_rd_a", ra_m, 8);
        chk("ident_rd_ab", ra_m + rb_m, 16);
        chk("ident_q_left", q_m.size(), 0);

        // All 16: 512 wraps to 0, saturates to 255.
        clr();
        load2(16, 16, 16, 16, 16, 16, 16, 16);
        for (int i = 0; i < 4; i++) push_m(i, 0);
        pulse(0);
        wait_idle(0);
        chk("wrap_q_left", q_m.size(), 0);
        chk("wrap_writes", wc_m, 4);
        for (int i = 0; i < 4; i++) begin
            wr_t e;
            e.a = i;
            e.v = 255;
            q_s.push_back(e);
        end
        pulse(1);
        wait_idle(1);
        chk("sat_q_left", q_s.size(), 0);
        chk("sat_writes", wc_s, 4);
        chk("sat_dones", dc_s, 1);

        // Second edge mid-run, then start held high long after.
        clr();
        load2(1, 2, 3, 4, 5, 6, 7, 8);
        push_m(0, 19); push_m(1, 22); push_m(2, 43); push_m(3, 50);
        @(posedge slow_clk);
        #1 st_m = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge slow_clk);
            #1;
            if (c == 4) st_m = 1'b0;
            if (c == 10) st_m = 1'b1;
        end
        st_m = 1'b0;
        chk("hold_writes", wc_m, 4);
        chk("hold_dones", dc_m, 1);
        chk("hold_busy_len", bc_m, 25);
        chk("hold_idle", busy_m, 0);
        chk("hold_q_left", q_m.size(), 0);

        // Reset after the second write.
        clr();
        push_m(0, 19); push_m(1, 22);
        pulse(0);
        for (int c = 0; c < 100 && wc_m < 2; c++) begin
            @(posedge slow_clk);
            #1;
        end
        chk("rst_reached_2", wc_m, 2);
        rst = 1'b1;
        #1 chk_quiet("rst_mid");
        @(posedge slow_clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge slow_clk);
        #1;
        chk("rst_writes", wc_m, 2);
        chk("rst_dones", dc_m, 0);
        chk("rst_idle", busy_m, 0);
        clr();
        push_m(0, 19); push_m(1, 22); push_m(2, 43); push_m(3, 50);
        pulse(0);
        wait_idle(0);
        chk("rerun_writes", wc_m, 4);
        chk("rerun_dones", dc_m, 1);
        chk("rerun_q_left", q_m.size(), 0);

        // 2x3 times 3x1: R0=1*7+2*8+3*9=50, R1=4*7+5*8+6*9=122.
        clr();
        for (int i = 0; i < 6; i++) mem_a[i] = 8'(i + 1);
        mem_b[0] = 8'd7; mem_b[1] = 8'd8; mem_b[2] = 8'd9;
        begin
            wr_t e;
            e.a = 0; e.v = 50;  q_o.push_back(e);
            e.a = 1; e.v = 122; q_o.push_back(e);
        end
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) q_ob.push_back(k);
        end
        pulse(2);
        wait_idle(2);
        chk("odd_busy_len", bc_o, 17);
        chk("odd_writes", wc_o, 2);
        chk("odd_dones", dc_o, 1);
        chk("odd_q_left", q_o.size() + q_ob.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
